// File: rtl/test_fifo_1p_sched.sv
// test_fifo_1p_sched
//   Schedules pushes and pops against an external single-port FIFO, which can
//   perform at most one operation per cycle. Input words pass through a
//   1-entry staging register and are written into the FIFO. FIFO reads are
//   issued only when there is guaranteed room in the 2-entry output buffer.
//   When a write and a read both want the FIFO port, the grant alternates.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   in_vld/in_rdy/in_data     upstream push handshake (in_rdy is registered)
//   out_vld/out_rdy/out_data  downstream pop handshake from the output buffer
//   fifo_wr/fifo_din          FIFO write strobe and write data
//   fifo_rd                   FIFO read strobe
//   fifo_mt/full/err          registered FIFO flags
//   fifo_rd_vld/fifo_dout     FIFO read data, valid one cycle after fifo_rd
//   occ                       FIFO occupancy as tracked by this scheduler
//   err                       sticky protocol error
module test_fifo_1p_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [WIDTH-1:0]               out_data,
  output logic                           fifo_wr,
  output logic                           fifo_rd,
  output logic [WIDTH-1:0]               fifo_din,
  input  logic                           fifo_mt,
  input  logic                           fifo_full,
  input  logic                           fifo_err,
  input  logic                           fifo_rd_vld,
  input  logic [WIDTH-1:0]               fifo_dout,
  output logic [$clog2(DEPTH+1)-1:0]     occ,
  output logic                           err
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] L_DEPTH = OW'(DEPTH);

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  logic             r_stg_vld;
  logic [WIDTH-1:0] r_stg_data;
  logic             r_in_rdy;
  logic [OW-1:0]    r_occ;
  logic             r_rd_prev;
  logic             r_post_rst;
  grant_e           r_last_grant;
  logic [WIDTH-1:0] r_obuf [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_obuf_cnt;
  logic             r_err;

  logic w_wr_cand;
  logic w_rd_cand;
  logic w_obuf_room;
  logic w_wr;
  logic w_rd;
  logic w_load;
  logic w_stg_vld_nxt;
  logic w_rd_vld_ok;
  logic w_push;
  logic w_pop;
  logic w_err_set;

  assign w_wr_cand = r_stg_vld && !fifo_full && (r_occ < L_DEPTH);

  // Read data always returns exactly one cycle after fifo_rd, so the only
  // read that can be outstanding is the one issued in the previous cycle.
  // Space is reserved for it before another read is allowed.
  assign w_obuf_room = (r_obuf_cnt == 2'd0) || ((r_obuf_cnt == 2'd1) && !r_rd_prev);
  assign w_rd_cand   = !fifo_mt && (r_occ != '0) && w_obuf_room;

  always_comb begin
    w_wr = 1'b0;
    w_rd = 1'b0;
    if (w_wr_cand && w_rd_cand) begin
      if (r_last_grant == GRANT_RD) w_wr = 1'b1;
      else                          w_rd = 1'b1;
    end else begin
      w_wr = w_wr_cand;
      w_rd = w_rd_cand;
    end
  end

  // Load and write-grant are mutually exclusive: load needs an empty staging
  // register, a write needs a full one.
  assign w_load        = in_vld && r_in_rdy;
  assign w_stg_vld_nxt = w_load ? 1'b1 : (w_wr ? 1'b0 : r_stg_vld);

  assign w_pop       = (r_obuf_cnt != 2'd0) && out_rdy;
  assign w_rd_vld_ok = fifo_rd_vld && r_rd_prev;
  assign w_push      = w_rd_vld_ok && ((r_obuf_cnt != 2'd2) || w_pop);

  // Read data arriving in the first cycle after reset belongs to a read
  // issued before reset and is silently discarded.
  assign w_err_set = fifo_err
                   || (fifo_rd_vld && !r_rd_prev && !r_post_rst)
                   || (w_rd_vld_ok && !w_push);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stg_vld    <= 1'b0;
      r_in_rdy     <= 1'b0;
      r_occ        <= '0;
      r_rd_prev    <= 1'b0;
      r_post_rst   <= 1'b1;
      r_last_grant <= GRANT_RD;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_obuf_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_post_rst <= 1'b0;
      r_stg_vld  <= w_stg_vld_nxt;
      r_in_rdy   <= !w_stg_vld_nxt;
      r_rd_prev  <= w_rd;
      if (w_wr) begin
        r_occ        <= r_occ + OW'(1);
        r_last_grant <= GRANT_WR;
      end else if (w_rd) begin
        r_occ        <= r_occ - OW'(1);
        r_last_grant <= GRANT_RD;
      end
      if (w_push) r_wr_ptr <= !r_wr_ptr;
      if (w_pop)  r_rd_ptr <= !r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_obuf_cnt <= r_obuf_cnt + 2'd1;
        2'b01:   r_obuf_cnt <= r_obuf_cnt - 2'd1;
        default: r_obuf_cnt <= r_obuf_cnt;
      endcase
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Data storage carries no reset; validity is tracked by the flags above.
  always_ff @(posedge clk) begin
    if (w_load) r_stg_data <= in_data;
    if (w_push) r_obuf[r_wr_ptr] <= fifo_dout;
  end

  assign in_rdy   = r_in_rdy;
  assign fifo_wr  = w_wr;
  assign fifo_rd  = w_rd;
  assign fifo_din = r_stg_data;
  assign out_vld  = (r_obuf_cnt != 2'd0);
  assign out_data = r_obuf[r_rd_ptr];
  assign occ      = r_occ;
  assign err      = r_err;

endmodule

// File: tb/tb_test_fifo_1p_sched.sv
module tb_test_fifo_1p_sched;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned OW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_mt   = 1'b1;
  logic             fifo_full = 1'b0;
  logic             fifo_err;
  logic             fifo_rd_vld;
  logic [WIDTH-1:0] fifo_dout;
  logic [OW-1:0]    occ;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cap = 0;
  int n_rd  = 0;
  logic [WIDTH-1:0] sb [$];

  // Behavioural single-port FIFO with registered flags and 1-cycle read data.
  logic [WIDTH-1:0] mq [$];
  logic             m_rd_vld = 1'b0;
  logic [WIDTH-1:0] m_dout   = '0;
  logic             inj_rd_vld;
  logic             inj_err;

  assign fifo_rd_vld = m_rd_vld | inj_rd_vld;
  assign fifo_dout   = m_dout;
  assign fifo_err    = inj_err;

  always #5 clk = ~clk;

  test_fifo_1p_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .fifo_mt(fifo_mt), .fifo_full(fifo_full), .fifo_err(fifo_err),
    .fifo_rd_vld(fifo_rd_vld), .fifo_dout(fifo_dout),
    .occ(occ), .err(err)
  );

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_rd_vld  <= 1'b0;
      fifo_mt   <= 1'b1;
      fifo_full <= 1'b0;
    end else begin
      m_rd_vld <= fifo_rd;
      if (fifo_rd && mq.size() > 0) m_dout <= mq.pop_front();
      if (fifo_wr) mq.push_back(fifo_din);
      fifo_mt   <= (mq.size() == 0);
      fifo_full <= (mq.size() >= DEPTH);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: accepted inputs are queued, every output pop is checked.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("wr_rd_exclusive", 32'(fifo_wr && fifo_rd), 32'd0);
      if (fifo_rd) n_rd++;
      if (in_vld && in_rdy) begin
        sb.push_back(in_data);
        n_cap++;
      end
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_data = WIDTH'($urandom);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    inj_rd_vld = 1'b0; inj_err = 1'b0;
    tick();
    sb.delete(); n_cap = 0; n_rd = 0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_n(input int n);
    int t = 0;
    in_vld = 1'b1;
    while (n_cap < n && t < 2000) begin
      tick();
      t++;
    end
    in_vld = 1'b0;
    chk("push_timeout", 32'(t >= 2000), 32'd0);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    in_vld = 1'b0; out_rdy = 1'b1;
    while ((sb.size() != 0 || occ != 0 || out_vld) && t < 1000) begin
      tick();
      t++;
    end
    chk(tag, 32'(t < 1000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic last_w;
    reset_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_data = '0;
    inj_rd_vld = 1'b0; inj_err = 1'b0;
    repeat (2) tick();
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_in_rdy_after", 32'(in_rdy), 32'd1);

    // Single-word latency on an empty system.
    out_rdy = 1'b1; in_vld = 1'b1; in_data = 16'hA5A5;
    tick();
    in_vld = 1'b0;
    chk("lat_wr_c1", 32'(fifo_wr), 32'd1);
    chk("lat_din_c1", 32'(fifo_din), 32'hA5A5);
    tick();
    chk("lat_rd_c2", 32'(fifo_rd), 32'd1);
    chk("lat_wr_c2", 32'(fifo_wr), 32'd0);
    tick();
    chk("lat_rdvld_c3", 32'(fifo_rd_vld), 32'd1);
    chk("lat_ovld_c3", 32'(out_vld), 32'd0);
    tick();
    chk("lat_ovld_c4", 32'(out_vld), 32'd1);
    chk("lat_odata_c4", 32'(out_data), 32'hA5A5);
    chk("lat_occ_c4", 32'(occ), 32'd0);
    tick();
    chk("lat_ovld_c5", 32'(out_vld), 32'd0);
    chk("lat_sb_empty", 32'(sb.size()), 32'd0);

    // Output stalled: only two reads may be issued.
    do_reset();
    push_n(22);
    repeat (20) tick();
    chk("hold_nrd", 32'(n_rd), 32'd2);
    chk("hold_occ", 32'(occ), 32'd20);
    chk("hold_ovld", 32'(out_vld), 32'd1);
    repeat (10) tick();
    chk("hold_nrd_late", 32'(n_rd), 32'd2);
    chk("hold_rd_now", 32'(fifo_rd), 32'd0);
    drain("hold_drain");

    // Fill until the FIFO is full: 64 stored, 2 in the output buffer,
    // 1 held in staging.
    do_reset();
    in_vld = 1'b1;
    repeat (250) tick();
    chk("fill_occ", 32'(occ), 32'd64);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_in_rdy", 32'(in_rdy), 32'd0);
    chk("fill_wr", 32'(fifo_wr), 32'd0);
    chk("fill_err", 32'(err), 32'd0);
    repeat (20) tick();
    chk("fill_ncap", 32'(n_cap), 32'(DEPTH + 3));
    chk("fill_in_rdy_late", 32'(in_rdy), 32'd0);
    drain("fill_drain");

    // Saturated traffic around occupancy 10.
    do_reset();
    push_n(12);
    repeat (10) tick();
    chk("sat_setup_occ", 32'(occ), 32'd10);
    in_vld = 1'b1;
    tick();
    out_rdy = 1'b1;
    last_w = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("sat_busy", 32'(fifo_wr || fifo_rd), 32'd1);
      chk("sat_alternate", 32'(fifo_wr), 32'(!last_w));
      chk("sat_occ_range", 32'(occ >= 10 && occ <= 11), 32'd1);
      last_w = fifo_wr;
      tick();
    end
    drain("sat_drain");

    // Sticky error sources and post-reset read-data suppression.
    do_reset();
    repeat (3) tick();
    inj_rd_vld = 1'b1;
    tick();
    inj_rd_vld = 1'b0;
    chk("err_spurious", 32'(err), 32'd1);
    repeat (3) tick();
    chk("err_hold", 32'(err), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("err_rst", 32'(err), 32'd0);
    reset_n = 1'b1; inj_rd_vld = 1'b1;
    tick();
    inj_rd_vld = 1'b0;
    chk("err_post_rst_rdvld", 32'(err), 32'd0);
    repeat (2) tick();
    inj_err = 1'b1;
    tick();
    inj_err = 1'b0;
    chk("err_fifo_err", 32'(err), 32'd1);
    tick();
    chk("err_fifo_hold", 32'(err), 32'd1);

    // Reset with words in flight.
    do_reset();
    push_n(3);
    reset_n = 1'b0;
    tick();
    sb.delete();
    chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
    chk("midrst_wr", 32'(fifo_wr), 32'd0);
    chk("midrst_rd", 32'(fifo_rd), 32'd0);
    chk("midrst_ovld", 32'(out_vld), 32'd0);
    chk("midrst_occ", 32'(occ), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    reset_n = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_stale", 32'(out_vld), 32'd0);
    end
    chk("midrst_err_late", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
